fetch_stage: RTL and testbench

Instruction fetch stage that owns the program counter and sits directly upstream and downstream of the next-PC select mux. It supplies `pc_plus4` to the mux's sequential input and takes the mux output back as `next_pc`. It issues one instruction-memory read per instruction over a valid/ready request channel and a valid-only response channel. It presents each fetched word to decode over a valid/ready handshake, and stops with a sticky fault when `next_pc` is misaligned.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_stage.sv | 120 ++++++++++++
 tb/tb_fetch_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, default reset PC, fetch FSM states.
// Ports: none (package).
// Imported by the fetch stage and anything else that needs XLEN-sized types.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int INSN_BYTES = 4;

  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one imem read per instruction,
// holds the fetched word for decode, and stops with a sticky fault on a
// misaligned next_pc.
// Ports: clk/reset (sync, active-high); next_pc in / pc_plus4 out to the
// next-PC mux; imem_req_* (valid/ready) and imem_resp_* (valid only) to
// memory; inst_* (valid/ready) to decode; fetch_fault/fault_pc/fetch_count
// status.
// Min 3 cycles per instruction; imem_req_ready low stalls in REQ, inst_ready
// low stalls in HOLD.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [XLEN-1:0] pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            fetch_fault,
  output logic [XLEN-1:0] fault_pc,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_inst;
  logic [XLEN-1:0] r_inst_pc;
  logic [XLEN-1:0] r_fault_pc;
  logic [XLEN-1:0] r_fetch_count;

  logic w_req_vld;
  logic w_inst_vld;
  logic w_fault;
  logic w_aligned;
  logic w_handoff;
  logic w_resp_take;

  assign w_aligned   = (next_pc[1:0] == 2'b00);
  assign w_handoff   = (r_state == HOLD) && inst_ready;
  // A response is only meaningful while waiting; anything else is ignored.
  assign w_resp_take = (r_state == WAIT) && imem_resp_valid;

  // Next state plus state-decoded outputs; the valid/fault outputs depend on
  // r_state alone so there is no input-to-output combinational path.
  always_comb begin
    w_state_nxt = r_state;
    w_req_vld   = 1'b0;
    w_inst_vld  = 1'b0;
    w_fault     = 1'b0;
    unique case (r_state)
      REQ: begin
        w_req_vld = 1'b1;
        if (imem_req_ready) w_state_nxt = WAIT;
      end
      WAIT: begin
        if (imem_resp_valid) w_state_nxt = HOLD;
      end
      HOLD: begin
        w_inst_vld = 1'b1;
        if (inst_ready) w_state_nxt = w_aligned ? REQ : FAULT;
      end
      FAULT: begin
        w_fault = 1'b1;
      end
      default: begin
        w_state_nxt = REQ;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= REQ;
      r_pc          <= RESET_PC;
      r_inst        <= '0;
      r_inst_pc     <= '0;
      r_fault_pc    <= '0;
      r_fetch_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_resp_take) begin
        r_inst    <= imem_resp_data;
        r_inst_pc <= r_pc;
      end
      // next_pc is only looked at on the decode handoff; a misaligned
      // target still counts as handed off but leaves pc where it was.
      if (w_handoff) begin
        r_fetch_count <= r_fetch_count + 32'd1;
        if (w_aligned) begin
          r_pc <= next_pc;
        end else begin
          r_fault_pc <= next_pc;
        end
      end
    end
  end

  assign pc             = r_pc;
  assign pc_plus4       = r_pc + XLEN'(INSN_BYTES);
  assign imem_addr      = r_pc;
  assign imem_req_valid = w_req_vld;
  assign inst_valid     = w_inst_vld;
  assign fetch_fault    = w_fault;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign fault_pc       = r_fault_pc;
  assign fetch_count    = r_fetch_count;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory responder, decode driver with a program-flow
// model, and a scoreboard monitor checking requests and handoffs.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] next_pc;
  logic [31:0] pc_plus4;
  logic [31:0] pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .reset           (reset),
    .next_pc         (next_pc),
    .pc_plus4        (pc_plus4),
    .pc              (pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst            (inst),
    .inst_pc         (inst_pc),
    .fetch_fault     (fetch_fault),
    .fault_pc        (fault_pc),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] cnt;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          mem_ready_pct = 100;
  int          mem_lat_min   = 0;
  int          mem_lat_max   = 0;
  bit          mem_spurious  = 1'b0;
  int          dec_ready_pct = 100;
  int          branch_pct    = 0;
  bit          force_en      = 1'b0;
  logic [31:0] force_np      = '0;
  logic [31:0] m_pc;
  logic [31:0] n_ho;
  logic [31:0] exp_req_q[$];
  exp_t        exp_inst_q[$];

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got %h with nothing expected", nm, act);
  endtask

  // Memory: owns the request-ready and response lines, drives at negedge+1.
  initial begin
    bit          mp_pend;
    logic [31:0] mp_addr;
    int          mp_delay;
    mp_pend = 1'b0; mp_addr = '0; mp_delay = 0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (reset) begin
        mp_pend = 1'b0;
        imem_req_ready = 1'b0;
      end else if (mp_pend) begin
        imem_req_ready = 1'b0;
        if (mp_delay == 0) begin
          imem_resp_valid = 1'b1;
          imem_resp_data  = mem_word(mp_addr);
          mp_pend = 1'b0;
        end else begin
          mp_delay--;
        end
      end else begin
        imem_req_ready = ($urandom_range(99) < mem_ready_pct);
        if (imem_req_valid && imem_req_ready) begin
          mp_pend  = 1'b1;
          mp_addr  = imem_addr;
          mp_delay = $urandom_range(mem_lat_max, mem_lat_min);
        end else if (mem_spurious && $urandom_range(9) == 0) begin
          imem_resp_valid = 1'b1;
        end
      end
    end
  end

  // Scoreboard monitor, samples at negedge+2.
  initial begin
    bit          pr_stall;
    bit          pr_hold;
    logic [31:0] pa, pi, pip, ea;
    exp_t        e;
    pr_stall = 1'b0; pr_hold = 1'b0; pa = '0; pi = '0; pip = '0;
    forever begin
      @(negedge clk);
      #2;
      if (reset) begin
        pr_stall = 1'b0;
        pr_hold  = 1'b0;
      end else begin
        if (imem_req_valid && pr_stall) chk("req_addr_stable", imem_addr, pa);
        if (inst_valid && pr_hold) begin
          chk("inst_stable", inst, pi);
          chk("inst_pc_stable", inst_pc, pip);
        end
        if (imem_req_valid && imem_req_ready) begin
          if (exp_req_q.size() == 0) fail_now("unexpected_req", imem_addr);
          else begin
            ea = exp_req_q.pop_front();
            chk("req_addr", imem_addr, ea);
            chk("req_pc_plus4", pc_plus4, ea + 32'd4);
          end
        end
        if (inst_valid && inst_ready) begin
          if (exp_inst_q.size() == 0) fail_now("unexpected_inst", inst_pc);
          else begin
            e = exp_inst_q.pop_front();
            chk("ho_inst_pc", inst_pc, e.pc);
            chk("ho_inst", inst, e.data);
            chk("ho_count", fetch_count, e.cnt);
          end
        end
        pr_stall = imem_req_valid && !imem_req_ready;
        pa       = imem_addr;
        pr_hold  = inst_valid && !inst_ready;
        pi       = inst;
        pip      = inst_pc;
      end
    end
  end

  // Decode side: drive at negedge, model the program flow, push expectations.
  task automatic drive_cycle();
    logic [31:0] np;
    @(negedge clk);
    inst_ready = ($urandom_range(99) < dec_ready_pct);
    np = $urandom;
    if (inst_valid && inst_ready) begin
      if (force_en) np = force_np;
      else if ($urandom_range(99) < branch_pct) np = $urandom & 32'hFFFF_FFFC;
      else np = m_pc + 32'd4;
      n_ho = n_ho + 32'd1;
      if (np[1:0] == 2'b00) begin
        m_pc = np;
        exp_req_q.push_back(np);
        exp_inst_q.push_back('{pc: np, data: mem_word(np), cnt: n_ho});
      end
    end
    next_pc = np;
    #3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; inst_ready = 1'b0; next_pc = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    exp_req_q.delete();
    exp_inst_q.delete();
    m_pc = RST_PC;
    n_ho = '0;
    exp_req_q.push_back(RST_PC);
    exp_inst_q.push_back('{pc: RST_PC, data: mem_word(RST_PC), cnt: 32'd0});
    #3;
  endtask

  // sel 0: inst_valid, 1: imem_req_valid, 2: waiting on memory.
  task automatic wait_cond(input int sel, input string nm);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 60 && !ok; k++) begin
      drive_cycle();
      case (sel)
        0:       ok = inst_valid;
        1:       ok = imem_req_valid;
        default: ok = !imem_req_valid && !inst_valid && !fetch_fault;
      endcase
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: condition not reached within 60 cycles", nm);
    end
  endtask

  initial begin
    int          acc_t[$];
    logic [31:0] acc_a[$];
    logic [31:0] a0, i0, c0;
    reset = 1'b1; inst_ready = 1'b0; next_pc = '0; m_pc = RST_PC; n_ho = '0;

    // Reset state and straight-line fetch.
    do_reset();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("rst_addr", imem_addr, RST_PC);
    chk("rst_pc_plus4", pc_plus4, RST_PC + 32'd4);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'd0);
    if (imem_req_valid && imem_req_ready) begin acc_t.push_back(0); acc_a.push_back(imem_addr); end
    for (int t = 1; t < 40 && n_ho < 4; t++) begin
      drive_cycle();
      if (imem_req_valid && imem_req_ready) begin acc_t.push_back(t); acc_a.push_back(imem_addr); end
    end
    chk("sl_req_count_ge4", {31'd0, acc_a.size() >= 4}, 32'd1);
    for (int i = 0; i < 4 && i < acc_a.size(); i++) begin
      chk("sl_addr", acc_a[i], 32'(4 * i));
      if (i > 0) chk("sl_spacing", 32'(acc_t[i] - acc_t[i-1]), 32'd3);
    end
    dec_ready_pct = 0;
    drive_cycle();
    chk("sl_count4", fetch_count, 32'd4);

    // Branch redirect from inst_pc 0x10 to 0x40.
    wait_cond(0, "br_hold");
    chk("br_inst_pc", inst_pc, 32'h10);
    force_en = 1'b1; force_np = 32'h40; dec_ready_pct = 100;
    drive_cycle();
    force_en = 1'b0; dec_ready_pct = 0;
    drive_cycle();
    chk("br_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("br_addr", imem_addr, 32'h40);
    chk("br_pc_plus4", pc_plus4, 32'h44);

    // Back-pressure on both sides.
    mem_ready_pct = 0; dec_ready_pct = 100;
    wait_cond(1, "bp_req");
    a0 = imem_addr;
    chk("bp_addr", a0, 32'h44);
    dec_ready_pct = 0;
    for (int k = 0; k < 5; k++) begin
      drive_cycle();
      chk("bp_req_held", {31'd0, imem_req_valid}, 32'd1);
      chk("bp_addr_held", imem_addr, a0);
    end
    mem_ready_pct = 100;
    wait_cond(0, "bp_hold");
    chk("bp_inst_pc", inst_pc, a0);
    chk("bp_inst", inst, mem_word(a0));
    i0 = inst; c0 = fetch_count;
    for (int k = 0; k < 4; k++) begin
      drive_cycle();
      chk("bp_inst_valid", {31'd0, inst_valid}, 32'd1);
      chk("bp_inst_held", inst, i0);
      chk("bp_inst_pc_held", inst_pc, a0);
    end
    dec_ready_pct = 100;
    drive_cycle();
    dec_ready_pct = 0;
    for (int k = 0; k < 3; k++) drive_cycle();
    chk("bp_one_handoff", fetch_count, c0 + 32'd1);

    // Randomized traffic.
    mem_ready_pct = 70; mem_lat_max = 3; mem_spurious = 1'b1;
    dec_ready_pct = 60; branch_pct = 20;
    for (int k = 0; k < 600; k++) drive_cycle();

    // Misaligned target.
    dec_ready_pct = 0; branch_pct = 0;
    wait_cond(0, "mis_hold");
    force_en = 1'b1; force_np = 32'h102; dec_ready_pct = 100;
    drive_cycle();
    force_en = 1'b0; dec_ready_pct = 50;
    for (int k = 0; k < 10; k++) begin
      drive_cycle();
      chk("mis_fault", {31'd0, fetch_fault}, 32'd1);
      chk("mis_fault_pc", fault_pc, 32'h102);
      chk("mis_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("mis_no_inst", {31'd0, inst_valid}, 32'd0);
    end
    do_reset();
    chk("mis_rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("mis_rst_fault_pc", fault_pc, 32'd0);
    chk("mis_rst_req", {31'd0, imem_req_valid}, 32'd1);
    chk("mis_rst_addr", imem_addr, RST_PC);
    chk("mis_rst_count", fetch_count, 32'd0);

    // PC wrap, then reset while waiting on memory.
    dec_ready_pct = 0;
    wait_cond(0, "wrap_hold");
    force_en = 1'b1; force_np = 32'hFFFF_FFFC; dec_ready_pct = 100;
    drive_cycle();
    force_en = 1'b0; dec_ready_pct = 0;
    mem_lat_min = 3; mem_lat_max = 3;
    drive_cycle();
    chk("wrap_pc", pc, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", pc_plus4, 32'd0);
    wait_cond(2, "wrap_wait");
    do_reset();
    chk("mid_rst_req", {31'd0, imem_req_valid}, 32'd1);
    chk("mid_rst_addr", imem_addr, RST_PC);
    chk("mid_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("mid_rst_count", fetch_count, 32'd0);
    mem_lat_min = 0; dec_ready_pct = 60; branch_pct = 20;
    for (int k = 0; k < 150; k++) drive_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
